// File: rtl/antares_pipe_pkg.sv
// Shared types and constants for the Antares pipeline hazard logic.
package antares_pipe_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    // Scoreboard entries store destinations at a fixed width so one entry type
    // serves every supported register-address width (up to 8 bits).
    localparam int SB_DEST_W = 8;

    localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_read;
        logic [SB_DEST_W-1:0] dest;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // True when an ID source operand depends on the result of an in-flight entry.
    // Register zero is hard-wired, so it never creates a dependency.
    function automatic logic src_match(
        input sb_entry_t            entry,
        input logic [SB_DEST_W-1:0] src,
        input logic                 uses
    );
        return (src != REG_ZERO) && uses && entry.valid && entry.reg_write &&
               (entry.dest == src);
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard entry register: hold keeps the entry, bubble clears it,
// otherwise it loads the entry presented by the previous stage.
module hazard_sb_stage
    import antares_pipe_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      hold,
    input  logic      bubble,
    input  sb_entry_t load_d,
    output sb_entry_t entry_q
);

    sb_entry_t entry_d;

    // Next entry: bubble has priority over hold, hold over load.
    always_comb begin
        entry_d = load_d;
        if (bubble) begin
            entry_d = SB_BUBBLE;
        end else if (hold) begin
            entry_d = entry_q;
        end
    end

    // Entry register, cleared asynchronously while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_q <= SB_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the Antares in-order pipeline.
// Tracks in-flight instructions in a per-stage scoreboard (EX .. WB) and
// derives PC / IF-ID / ID-EX enables, flushes and bubbles from it.
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall/redirect counters.
module hazard_ctrl
    import antares_pipe_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRs,
    input  logic                  idUsesRt,
    input  logic                  idRegWrite,
    input  logic                  idMemRead,
    input  logic [REG_ADDR_W-1:0] idDest,
    input  logic                  idRedirect,
    input  logic                  exBusy,
    output logic                  pcWrite,
    output logic                  ifidWrite,
    output logic                  ifidFlush,
    output logic                  idexWrite,
    output logic                  idexFlush,
    output logic                  exmemFlush,
    output logic                  loadUseStall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      luStallCnt,
    output logic [CNT_W-1:0]      busyStallCnt,
    output logic [CNT_W-1:0]      redirectCnt
`endif
);

    // Back-end entries: 1 = EX ... N = WB.
    localparam int N = STAGES - 2;

    sb_entry_t sb_q    [1:N];
    sb_entry_t sb_load [1:N];
    logic [N:1] sb_hold;
    logic [N:1] sb_bubble;

    logic [SB_DEST_W-1:0] rs_ext;
    logic [SB_DEST_W-1:0] rt_ext;
    logic                 lu_hazard;
    logic                 redirect_taken;

    assign rs_ext = SB_DEST_W'(idRs);
    assign rt_ext = SB_DEST_W'(idRt);

    genvar k;
    generate
        for (k = 1; k <= N; k++) begin : g_sb
            if (k == 1) begin : g_head
                assign sb_load[k] = '{valid:     idValid,
                                      reg_write: idRegWrite,
                                      mem_read:  idMemRead,
                                      dest:      SB_DEST_W'(idDest)};
            end else begin : g_tail
                assign sb_load[k] = sb_q[k-1];
            end

            hazard_sb_stage u_stage (
                .clock   (clock),
                .reset   (reset),
                .hold    (sb_hold[k]),
                .bubble  (sb_bubble[k]),
                .load_d  (sb_load[k]),
                .entry_q (sb_q[k])
            );
        end
    endgenerate

    // Load-use: a load still within its non-forwardable window feeds an ID source.
    always_comb begin
        lu_hazard = 1'b0;
        for (int i = 1; i <= LOAD_LATENCY; i++) begin
            if (sb_q[i].mem_read &&
                (src_match(sb_q[i], rs_ext, idUsesRs) ||
                 src_match(sb_q[i], rt_ext, idUsesRt))) begin
                lu_hazard = 1'b1;
            end
        end
        lu_hazard = lu_hazard & idValid;
    end

    // Prioritised pipeline control: busy EX, then load-use, then redirect.
    always_comb begin
        pcWrite        = 1'b1;
        ifidWrite      = 1'b1;
        idexWrite      = 1'b1;
        ifidFlush      = 1'b0;
        idexFlush      = 1'b0;
        exmemFlush     = 1'b0;
        loadUseStall   = 1'b0;
        sb_hold        = '0;
        sb_bubble      = '0;
        redirect_taken = 1'b0;

        if (exBusy) begin
            // EX keeps its instruction; MEM sees a bubble; older ones drain.
            pcWrite      = 1'b0;
            ifidWrite    = 1'b0;
            idexWrite    = 1'b0;
            exmemFlush   = 1'b1;
            sb_hold[1]   = 1'b1;
            sb_bubble[2] = 1'b1;
        end else if (lu_hazard) begin
            // Redirect is not trusted here: ID operands are stale.
            pcWrite      = 1'b0;
            ifidWrite    = 1'b0;
            idexFlush    = 1'b1;
            loadUseStall = 1'b1;
            sb_bubble[1] = 1'b1;
        end else if (idRedirect && idValid) begin
            ifidFlush      = 1'b1;
            redirect_taken = 1'b1;
        end

        if (!reset) begin
            pcWrite        = 1'b0;
            ifidWrite      = 1'b0;
            idexWrite      = 1'b0;
            ifidFlush      = 1'b1;
            idexFlush      = 1'b1;
            exmemFlush     = 1'b1;
            loadUseStall   = 1'b0;
            redirect_taken = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_stall_cnt_q,   lu_stall_cnt_d;
    logic [CNT_W-1:0] busy_stall_cnt_q, busy_stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q,   redirect_cnt_d;

    // Saturating event counters.
    always_comb begin
        lu_stall_cnt_d   = lu_stall_cnt_q;
        busy_stall_cnt_d = busy_stall_cnt_q;
        redirect_cnt_d   = redirect_cnt_q;
        if (loadUseStall && (lu_stall_cnt_q != '1)) begin
            lu_stall_cnt_d = lu_stall_cnt_q + 1'b1;
        end
        if (exBusy && (busy_stall_cnt_q != '1)) begin
            busy_stall_cnt_d = busy_stall_cnt_q + 1'b1;
        end
        if (redirect_taken && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lu_stall_cnt_q   <= '0;
            busy_stall_cnt_q <= '0;
            redirect_cnt_q   <= '0;
        end else begin
            lu_stall_cnt_q   <= lu_stall_cnt_d;
            busy_stall_cnt_q <= busy_stall_cnt_d;
            redirect_cnt_q   <= redirect_cnt_d;
        end
    end

    assign luStallCnt   = lu_stall_cnt_q;
    assign busyStallCnt = busy_stall_cnt_q;
    assign redirectCnt  = redirect_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the Antares in-order MIPS pipeline.
- Keeps a per-stage scoreboard of in-flight instructions: valid, regWrite, memRead, destination register.
- Generates the pipeline control signals from that scoreboard: PC/IF-ID write enables, flushes and bubble insertion.
- Covers load-use hazards, a multi-cycle EX unit (busy) and ID-resolved branches/jumps, for any stage count and load latency.

Parameters:
- STAGES, 5, total pipeline stages (IF, ID, then STAGES-2 tracked back-end stages); legal range 4..8.
- REG_ADDR_W, 5, register address width.
- LOAD_LATENCY, 1, number of back-end stages after EX in which load data is not yet forwardable; legal range 1..STAGES-3.
- CNT_W, 32, performance counter width (used only with PERF_CNT_EN).

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- idValid, in, 1, ID holds a real instruction.
- idRs, in, REG_ADDR_W, ID source register 1.
- idRt, in, REG_ADDR_W, ID source register 2.
- idUsesRs, in, 1, ID instruction reads rs.
- idUsesRt, in, 1, ID instruction reads rt.
- idRegWrite, in, 1, ID instruction writes a register.
- idMemRead, in, 1, ID instruction is a load.
- idDest, in, REG_ADDR_W, resolved destination register (after regDst mux).
- idRedirect, in, 1, branch taken or jump resolved in ID.
- exBusy, in, 1, multi-cycle EX unit not finished.
- pcWrite, out, 1, PC update enable.
- ifidWrite, out, 1, IF/ID register enable.
- ifidFlush, out, 1, IF/ID register clear.
- idexWrite, out, 1, ID/EX register enable.
- idexFlush, out, 1, insert bubble into ID/EX.
- exmemFlush, out, 1, insert bubble into EX/MEM.
- loadUseStall, out, 1, status: load-use hazard this cycle.

Behaviour:
- Scoreboard: entries sb[1..STAGES-2]; sb[1]=EX, sb[STAGES-2]=last (WB). Each entry holds {valid, regWrite, memRead, dest}. The register file writes before it reads, so the last entry never causes a hazard.
- Reset (reset=0, asynchronous): all sb valid bits cleared; counters cleared.
- Outputs while reset is asserted: pcWrite=0, ifidWrite=0, idexWrite=0, ifidFlush=1, idexFlush=1, exmemFlush=1, loadUseStall=0.
- Outputs are combinational from inputs and scoreboard; zero-cycle latency.
- Source match: src!=0 AND uses bit set AND sb[k].valid AND sb[k].regWrite AND sb[k].dest==src.
- Load-use hazard (LU): idValid AND (rs or rt match) for some k in 1..LOAD_LATENCY with sb[k].memRead=1.
- Priority 1, exBusy=1:
  - pcWrite=0, ifidWrite=0, idexWrite=0, exmemFlush=1.
  - sb[1] holds; sb[2] receives a bubble; entries beyond sb[2] advance.
  - LU and idRedirect are ignored this cycle.
- Priority 2, LU and not exBusy:
  - pcWrite=0, ifidWrite=0, idexFlush=1, loadUseStall=1.
  - sb[1] receives a bubble; all other entries shift.
  - idRedirect is ignored, since ID operands are stale.
- Priority 3, idRedirect and idValid, no stall:
  - pcWrite=1, ifidFlush=1.
  - The ID instruction advances normally into sb[1].
- Default: all write enables 1, all flushes 0; sb[k+1]<=sb[k]; sb[1]<={idValid, idRegWrite, idMemRead, idDest}.
- An instruction with idValid=0 enters the scoreboard as valid=0.
- dest=0 never matches, even when regWrite=1.
- A reset arriving mid-stall clears the scoreboard; the first cycle after release has no hazards.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three additional output ports exist:
  - luStallCnt (CNT_W): cycles with LU stall.
  - busyStallCnt (CNT_W): cycles with exBusy.
  - redirectCnt (CNT_W): taken redirects.
- Counters saturate at all-ones and clear on reset.
- When undefined, the ports and registers are absent; core behaviour is identical.

Decomposition:
- Package antares_pipe_pkg holds:
  - the sb_entry_t struct (valid, regWrite, memRead, dest);
  - REG_ADDR_W default;
  - register-zero constant REG_ZERO.
- One sub-module, hazard_sb_stage: a single scoreboard entry register with hold, bubble and load controls and async active-low clear. It is instantiated STAGES-2 times.

Test Plan:
- Load then dependent, STAGES=5, LOAD_LATENCY=1: `lw $8` then `add $9,$8,$1` in ID → one cycle with pcWrite=0, ifidWrite=0, idexFlush=1, loadUseStall=1; next cycle all write enables 1.
- Independent load: `lw $8` then `add $9,$2,$3` → no stall; load from `$0` destination with consumer reading `$0` → no stall.
- exBusy held 3 cycles with a load in EX and its consumer in ID → pcWrite=0 and exmemFlush=1 for exactly 3 cycles; LU stall follows for 1 cycle after exBusy drops.
- idRedirect=1 with no hazard → ifidFlush=1, pcWrite=1 for 1 cycle; idRedirect=1 coinciding with LU → ifidFlush=0, stall wins.
- LOAD_LATENCY=2, STAGES=6: consumer two instructions after the load → 1 stall cycle; consumer directly after → 2 stall cycles.
- Reset (reset=0) asserted during an LU stall → outputs go to reset values immediately; after release with idValid=0, write enables are 1 and the scoreboard is empty. With HAZARD_PERF_CNT_EN, counters read 0.
